// File: rtl/lockin_iq_accumulator.sv
// -----------------------------------------------------------------------------
// lockin_iq_accumulator
//
// Lock-in amplifier back end. One measurement integrates N_lockin*M samples of
// data_in multiplied by an in-phase (ref_sin) and a quadrature (ref_cos)
// reference. The measurement is aligned to the reference: after start, it
// waits for a sample flagged with ref_sync before it accepts anything.
//
// The pipeline has three stages:
//   acceptance edge e : products data_in*ref are registered (2W bits, signed)
//   edge e+1          : registered products are sign-extended and accumulated
//   edge e+2          : after the last sample, the sums are copied to the
//                       result registers and done pulses for one cycle
//
// Ports
//   Clock       in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   request one measurement (only honoured in IDLE)
//   data_in     in   signed input sample, W bits
//   ref_sin     in   signed in-phase reference, W bits
//   ref_cos     in   signed quadrature reference, W bits
//   data_valid  in   qualifies data_in, ref_sin, ref_cos and ref_sync
//   ref_sync    in   marks the phase-zero sample of a reference period
//   busy        out  measurement in progress (ARM, ACC, DONE)
//   done        out  one-cycle pulse when res_fase/res_cuad are updated
//   res_fase    out  sum of data_in*ref_sin, N bits, two's complement
//   res_cuad    out  sum of data_in*ref_cos, N bits, two's complement
//   sync_err    out  sticky flag: ref_sync seen off a period boundary
// -----------------------------------------------------------------------------
module lockin_iq_accumulator #(
  parameter int N        = 64,
  parameter int N_lockin = 2,
  parameter int M        = 32,
  parameter int W        = 16
) (
  input  logic                Clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic signed [W-1:0] data_in,
  input  logic signed [W-1:0] ref_sin,
  input  logic signed [W-1:0] ref_cos,
  input  logic                data_valid,
  input  logic                ref_sync,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        res_fase,
  output logic [N-1:0]        res_cuad,
  output logic                sync_err
);

  localparam int TOTAL = N_lockin * M;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = (N_lockin > 1) ? $clog2(N_lockin) : 1;

  localparam logic [CW-1:0] LAST_IDX   = CW'(TOTAL - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N_lockin - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Index of the next sample to be accepted, and that index mod N_lockin.
  // A separate phase counter avoids a general modulo operator.
  logic [CW-1:0] count_reg;
  logic [PW-1:0] phase_reg;

  logic prod_valid_reg;  // product registers hold an un-accumulated sample
  logic last_prod_reg;   // ... and that sample is the final one
  logic last_acc_reg;    // accumulators now hold the final sums
  logic done_reg;
  logic sync_err_reg;

  // Decoded control for the current cycle
  logic clear;        // start accepted: clear accumulators, counter, sync_err
  logic accept;       // this cycle's sample enters the pipeline
  logic accept_last;  // ... and it is the final sample of the measurement
  logic load_res;     // copy the final sums to the outputs
  logic sync_bad;     // ref_sync on an accepted sample off a period boundary

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    clear       = 1'b0;
    accept      = 1'b0;
    accept_last = 1'b0;
    load_res    = 1'b0;
    case (state_reg)
      IDLE: begin
        // The done cycle is spent in IDLE; start is deliberately ignored there
        if (start && !done_reg) begin
          clear      = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        // Wait for phase zero; unsynchronised samples are dropped
        if (data_valid && ref_sync) begin
          accept     = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (data_valid) begin
          accept = 1'b1;
          if (count_reg == LAST_IDX) begin
            accept_last = 1'b1;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        // Stay until the last product has been folded into the accumulators
        if (last_acc_reg) begin
          load_res   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample 0 is accepted in ARM with phase 0, so only ACC needs checking.
  assign sync_bad = (state_reg == ACC) && accept && ref_sync && (phase_reg != '0);

  // ---------------------------------------------------------------------------
  // Sample counter, pipeline flags, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg      <= '0;
      phase_reg      <= '0;
      prod_valid_reg <= 1'b0;
      last_prod_reg  <= 1'b0;
      last_acc_reg   <= 1'b0;
      done_reg       <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      if (clear) begin
        count_reg <= '0;
        phase_reg <= '0;
      end else if (accept) begin
        count_reg <= count_reg + CW'(1);
        phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + PW'(1);
      end

      prod_valid_reg <= accept;
      last_prod_reg  <= accept_last;
      last_acc_reg   <= last_prod_reg;
      done_reg       <= load_res;

      if (clear) begin
        sync_err_reg <= 1'b0;
      end else if (sync_bad) begin
        sync_err_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: lane 0 is the in-phase channel, lane 1 the quadrature channel
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] ref_lane [2];
  logic signed [N-1:0] res_lane [2];

  assign ref_lane[0] = ref_sin;
  assign ref_lane[1] = ref_cos;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic signed [2*W-1:0] prod_next;
    logic signed [2*W-1:0] prod_reg;
    logic signed [N-1:0]   acc_reg;
    logic signed [N-1:0]   res_reg;

    // Both operands are signed, so the full 2W-bit product is exact
    assign prod_next = data_in * ref_lane[gi];

    always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
        prod_reg <= '0;
        acc_reg  <= '0;
        res_reg  <= '0;
      end else begin
        if (accept) begin
          prod_reg <= prod_next;
        end

        // Signed size cast sign-extends the product to the accumulator width
        if (clear) begin
          acc_reg <= '0;
        end else if (prod_valid_reg) begin
          acc_reg <= acc_reg + N'(prod_reg);
        end

        // Results only change here, so partial sums are never visible
        if (load_res) begin
          res_reg <= acc_reg;
        end
      end
    end

    assign res_lane[gi] = res_reg;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign sync_err = sync_err_reg;
  assign res_fase = res_lane[0];
  assign res_cuad = res_lane[1];

endmodule

// File: tb/tb_lockin_iq_accumulator.sv
// -----------------------------------------------------------------------------
// tb_lockin_iq_accumulator
//
// Directed runs with hand-computed sums. The driver pushes the expected result
// and the cycle on which done must appear; an independent monitor pops and
// compares whenever done is high.
// -----------------------------------------------------------------------------
module tb_lockin_iq_accumulator;

  localparam int N = 64;
  localparam int W = 16;

  localparam logic [63:0] FULL_POS = 64'd2097088000;   // 64 * 1000 * 32767
  localparam logic [63:0] FULL_NEG = -64'sd2097088000;

  logic                Clock;
  logic                reset_n;
  logic                start;
  logic signed [W-1:0] data_in;
  logic signed [W-1:0] ref_sin;
  logic signed [W-1:0] ref_cos;
  logic                data_valid;
  logic                ref_sync;
  logic                busy;
  logic                done;
  logic [N-1:0]        res_fase;
  logic [N-1:0]        res_cuad;
  logic                sync_err;

  lockin_iq_accumulator #(.N(N), .N_lockin(2), .M(32), .W(W)) dut (
    .Clock      (Clock),
    .reset_n    (reset_n),
    .start      (start),
    .data_in    (data_in),
    .ref_sin    (ref_sin),
    .ref_cos    (ref_cos),
    .data_valid (data_valid),
    .ref_sync   (ref_sync),
    .busy       (busy),
    .done       (done),
    .res_fase   (res_fase),
    .res_cuad   (res_cuad),
    .sync_err   (sync_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] f;
    logic [63:0] c;
    logic        err;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] prev_f = '0;
  logic [63:0] prev_c = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one line per completed measurement
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_fase", res_fase, e.f);
          chk("res_cuad", res_cuad, e.c);
          chk("sync_err", 64'(sync_err), 64'(e.err));
          chk("done_cycle", 64'(cyc), 64'(e.at));
          $display("done at cycle %0d: res_fase=%0d res_cuad=%0d sync_err=%0b",
                   cyc, $signed(res_fase), $signed(res_cuad), sync_err);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("sync_err_cleared", 64'(sync_err), 64'd0);
  endtask

  task automatic drive_sample(input int din, input int rs, input int rc, input logic sy);
    @(negedge Clock);
    data_valid = 1'b1;
    data_in    = 16'(din);
    ref_sin    = 16'(rs);
    ref_cos    = 16'(rc);
    ref_sync   = sy;
  endtask

  // Idle cycles carry garbage, including ref_sync, which must all be ignored
  task automatic drive_gap(input int n);
    for (int g = 0; g < n; g++) begin
      @(negedge Clock);
      data_valid = 1'b0;
      data_in    = 16'(12345);
      ref_sin    = 16'(-777);
      ref_cos    = 16'(555);
      ref_sync   = 1'b1;
    end
  endtask

  task automatic run_meas(input string tag, input int din, input int rs, input int rc,
                          input int gap, input int extra_sync, input int junk,
                          input logic [63:0] ef, input logic [63:0] ec, input logic eerr);
    exp_t e;
    pulse_start();
    for (int j = 0; j < junk; j++) drive_sample(7000, 32767, 32767, 1'b0);
    for (int i = 0; i < 64; i++) begin
      drive_sample(din, rs, rc, ((i % 2) == 0) || (i == extra_sync));
      if (i == 63) begin
        @(posedge Clock);
        #1;
        e.f = ef; e.c = ec; e.err = eerr; e.at = cyc + 2;
        exp_q.push_back(e);
        // Accumulation is in flight; the outputs still show the previous run
        chk("res_fase_hold", res_fase, prev_f);
        chk("res_cuad_hold", res_cuad, prev_c);
      end else begin
        drive_gap(gap);
      end
    end
    drive_gap(1);
    @(negedge Clock);
    // This negedge falls inside the done cycle: start must be ignored
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge Clock);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    $display("run %s: expected res_fase=%0d res_cuad=%0d sync_err=%0b",
             tag, $signed(ef), $signed(ec), eerr);
    prev_f = ef;
    prev_c = ec;
  endtask

  task automatic run_abort();
    pulse_start();
    for (int i = 0; i <= 30; i++) drive_sample(1000, 32767, 0, (i % 2) == 0);
    @(negedge Clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_res_fase", res_fase, 64'd0);
    chk("abort_res_cuad", res_cuad, 64'd0);
    chk("abort_sync_err", 64'(sync_err), 64'd0);
    @(negedge Clock);
    reset_n    = 1'b1;
    data_valid = 1'b0;
    repeat (8) @(negedge Clock);
    $display("run abort: reset after sample 30, outputs cleared");
    prev_f = '0;
    prev_c = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    data_in    = '0;
    ref_sin    = '0;
    ref_cos    = '0;
    data_valid = 1'b0;
    ref_sync   = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_res_fase", res_fase, 64'd0);
    chk("reset_res_cuad", res_cuad, 64'd0);
    chk("reset_sync_err", 64'(sync_err), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clock);

    run_meas("basic",      1000, 32767, 0,     0, -1, 0, FULL_POS, 64'd0,    1'b0);
    run_meas("quadrature", -1000, 0,    32767, 0, -1, 0, 64'd0,    FULL_NEG, 1'b0);
    run_meas("gapped",     1000, 32767, 0,     2, -1, 0, FULL_POS, 64'd0,    1'b0);
    run_meas("pre_junk",   1000, 32767, 0,     0, -1, 5, FULL_POS, 64'd0,    1'b0);
    run_meas("bad_sync",   1000, 32767, 0,     0,  3, 0, FULL_POS, 64'd0,    1'b1);
    run_meas("after_err",  1000, 32767, 0,     0, -1, 0, FULL_POS, 64'd0,    1'b0);
    run_abort();
    run_meas("after_rst",  1000, 32767, 0,     0, -1, 0, FULL_POS, 64'd0,    1'b0);

    repeat (4) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
